// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - request/result interface of the RV32M multiply/divide sequencer
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, funct3, a, b, flush,
        input  busy, stall, done, result
    );

    modport slave (
        input  start, funct3, a, b, flush,
        output busy, stall, done, result
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M shift-add multiply / restoring divide with pipeline stall
// Optional build macro MULDIV_ZERO_SKIP_EN short-cuts zero operands straight to DONE.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    muldiv_sequencer_if.slave  bus
);
    localparam int W2 = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, opnd_q, opnd_d, result_q, result_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d, neg_rem_q, neg_rem_d;

    logic             is_div, a_signed, b_signed, a_neg, b_neg;
    logic             b_zero, ovf, special_hit, zero_hit;
    logic [WIDTH-1:0] abs_a, abs_b, special_val, step_opnd, quot, rem, fix_result;
    logic [W2-1:0]    step_acc, mul_next, div_next, step_next, prod;
    logic [WIDTH:0]   mul_sum, div_trial;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            opnd_q    <= '0;
            result_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            opnd_q    <= opnd_d;
            result_q  <= result_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    // Datapath: PREP feeds the first iteration from the absolute operands, CALC from the accumulator.
    always_comb begin
        is_div   = op_q[2];
        a_signed = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
        b_signed = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
        a_neg    = a_signed & a_q[WIDTH-1];
        b_neg    = b_signed & b_q[WIDTH-1];
        abs_a    = a_neg ? ({WIDTH{1'b0}} - a_q) : a_q;
        abs_b    = b_neg ? ({WIDTH{1'b0}} - b_q) : b_q;

        step_acc  = (state_q == S_PREP) ? {{WIDTH{1'b0}}, abs_a} : acc_q;
        step_opnd = (state_q == S_PREP) ? abs_b : opnd_q;

        mul_sum   = {1'b0, step_acc[W2-1:WIDTH]} + (step_acc[0] ? {1'b0, step_opnd} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, step_acc[WIDTH-1:1]};
        div_trial = step_acc[W2-1:WIDTH-1] - {1'b0, step_opnd};
        div_next  = div_trial[WIDTH] ? {step_acc[W2-2:0], 1'b0}
                                     : {div_trial[WIDTH-1:0], step_acc[WIDTH-2:0], 1'b1};
        step_next = is_div ? div_next : mul_next;

        b_zero      = (b_q == '0);
        ovf         = !op_q[0] && (a_q == MIN_INT) && (b_q == '1);
        special_hit = is_div && (b_zero || ovf);
        if (b_zero) special_val = op_q[1] ? a_q : '1;
        else        special_val = op_q[1] ? '0 : MIN_INT;
`ifdef MULDIV_ZERO_SKIP_EN
        zero_hit = is_div ? ((a_q == '0) && !b_zero) : ((a_q == '0) || b_zero);
`else
        zero_hit = 1'b0;
`endif

        prod = neg_q ? ({W2{1'b0}} - acc_q) : acc_q;
        quot = neg_q ? ({WIDTH{1'b0}} - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        rem  = neg_rem_q ? ({WIDTH{1'b0}} - acc_q[W2-1:WIDTH]) : acc_q[W2-1:WIDTH];
        case (op_q)
            3'b000:                 fix_result = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod[W2-1:WIDTH];
            3'b100, 3'b101:         fix_result = quot;
            default:                fix_result = rem;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        opnd_d    = opnd_q;
        result_d  = result_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;

        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        op_d    = bus.funct3;
                        a_d     = bus.a;
                        b_d     = bus.b;
                        state_d = S_PREP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_PREP: begin
                    cnt_d = '0;
                    if (special_hit) begin
                        result_d = special_val;
                        state_d  = S_DONE;
                    end else if (zero_hit) begin
                        result_d = '0;
                        state_d  = S_DONE;
                    end else begin
                        // cnt counts completed iterations; the first one happens here.
                        acc_d     = step_next;
                        opnd_d    = abs_b;
                        neg_d     = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        cnt_d     = CNT_ONE;
                        state_d   = S_CALC;
                    end
                end
                S_CALC: begin
                    acc_d = step_next;
                    if (cnt_q == CNT_LAST) state_d = S_FIX;
                    else                   cnt_d   = cnt_q + CNT_ONE;
                end
                S_FIX: begin
                    result_d = fix_result;
                    state_d  = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
    assign bus.stall  = (state_q == S_PREP) || (state_q == S_CALC) || (state_q == S_FIX) ||
                        (((state_q == S_IDLE) || (state_q == S_DONE)) && bus.start && !bus.flush);
endmodule
